// File: rtl/skip_result_buffer_pkg.sv
// Shared types and defaults for the skip result buffer.
// Defaults here are the widths the fetch skip path is built around.
package VSTypes;

    localparam int RB_DEPTH_DEF = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int RB_IDX_W     = $clog2(RB_DEPTH_DEF);

    localparam logic [15:0] HIT_MAX = 16'hFFFF;

    typedef logic [RB_IDX_W-1:0] RbIdxType;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] rs1Data;
        logic [DATA_W_DEF-1:0] rs2Data;
        RbIdxType              rdIdx;
        logic                  miss;
    } RbRspType;

endpackage

// File: rtl/skip_result_buffer_array.sv
// Result storage with per-entry valid bits; writeback beats invalidate on the same entry.
// Reads are combinational; the top registers them into the response stage.
module skip_rb_array #(
    parameter int RB_DEPTH = 16,
    parameter int DATA_W   = 32,
    localparam int IDX_W   = $clog2(RB_DEPTH)
) (
    input  logic                ClockIn,
    input  logic                ResetIn,
    input  logic                WbValidIn,
    input  logic [IDX_W-1:0]    WbRbIdxIn,
    input  logic [DATA_W-1:0]   WbDataIn,
    input  logic                InvalidateIn,
    input  logic [RB_DEPTH-1:0] InvalidateMaskIn,
    input  logic [IDX_W-1:0]    Rs1IdxIn,
    input  logic [IDX_W-1:0]    Rs2IdxIn,
    output logic [DATA_W-1:0]   Rs1DataOut,
    output logic                Rs1ValidOut,
    output logic [DATA_W-1:0]   Rs2DataOut,
    output logic                Rs2ValidOut,
    output logic [RB_DEPTH-1:0] RbValidOut
);

    logic [DATA_W-1:0]   mem [RB_DEPTH];
    logic [RB_DEPTH-1:0] valid;
    logic [RB_DEPTH-1:0] validNext;

    // Write is applied after the mask so it wins on a shared entry.
    always_comb begin
        validNext = valid;
        if (InvalidateIn) begin
            validNext = validNext & ~InvalidateMaskIn;
        end
        if (WbValidIn) begin
            validNext[WbRbIdxIn] = 1'b1;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (ResetIn) begin
            valid <= '0;
        end else begin
            valid <= validNext;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (WbValidIn && !ResetIn) begin
            mem[WbRbIdxIn] <= WbDataIn;
        end
    end

    assign Rs1DataOut  = mem[Rs1IdxIn];
    assign Rs2DataOut  = mem[Rs2IdxIn];
    assign Rs1ValidOut = valid[Rs1IdxIn];
    assign Rs2ValidOut = valid[Rs2IdxIn];
    assign RbValidOut  = valid;

endmodule

// File: rtl/skip_result_buffer.sv
// Result buffer serving operand reads to the fetch skip logic through a one-deep response stage.
// Optional SKIP_RB_BYPASS_EN forwards a same-cycle writeback into an accepted read.
module skip_result_buffer
    import VSTypes::*;
#(
    parameter int RB_DEPTH = RB_DEPTH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    localparam int IDX_W   = $clog2(RB_DEPTH)
) (
    input  logic                ClockIn,
    input  logic                ResetIn,
    input  logic                WbValidIn,
    input  logic [IDX_W-1:0]    WbRbIdxIn,
    input  logic [DATA_W-1:0]   WbDataIn,
    input  logic                InvalidateIn,
    input  logic [RB_DEPTH-1:0] InvalidateMaskIn,
    input  logic                ReqValidIn,
    output logic                ReqReadyOut,
    input  logic                Rs1ReadEnIn,
    input  logic                Rs2ReadEnIn,
    input  logic [IDX_W-1:0]    Rs1IdxIn,
    input  logic [IDX_W-1:0]    Rs2IdxIn,
    input  logic [IDX_W-1:0]    RdIdxIn,
    output logic                RspValidOut,
    input  logic                RspReadyIn,
    output logic [DATA_W-1:0]   Rs1DataOut,
    output logic [DATA_W-1:0]   Rs2DataOut,
    output logic [IDX_W-1:0]    RdIdxOut,
    output logic                RspMissOut,
    output logic [RB_DEPTH-1:0] RbValidOut,
    output logic [15:0]         HitCountOut
);

    typedef struct packed {
        logic [DATA_W-1:0] rs1Data;
        logic [DATA_W-1:0] rs2Data;
        logic [IDX_W-1:0]  rdIdx;
        logic              miss;
    } rspType;

    logic [DATA_W-1:0] arrRs1Data, arrRs2Data, rs1Data, rs2Data;
    logic              arrRs1Valid, arrRs2Valid, rs1Valid, rs2Valid;
    logic              rspValid, reqAccept;
    logic [15:0]       hitCount;
    rspType            rsp, rspNext;

    skip_rb_array #(
        .RB_DEPTH (RB_DEPTH),
        .DATA_W   (DATA_W)
    ) uArray (
        .ClockIn          (ClockIn),
        .ResetIn          (ResetIn),
        .WbValidIn        (WbValidIn),
        .WbRbIdxIn        (WbRbIdxIn),
        .WbDataIn         (WbDataIn),
        .InvalidateIn     (InvalidateIn),
        .InvalidateMaskIn (InvalidateMaskIn),
        .Rs1IdxIn         (Rs1IdxIn),
        .Rs2IdxIn         (Rs2IdxIn),
        .Rs1DataOut       (arrRs1Data),
        .Rs1ValidOut      (arrRs1Valid),
        .Rs2DataOut       (arrRs2Data),
        .Rs2ValidOut      (arrRs2Valid),
        .RbValidOut       (RbValidOut)
    );

    assign ReqReadyOut = !rspValid || RspReadyIn;
    assign reqAccept   = ReqValidIn && ReqReadyOut;

    always_comb begin
        rs1Valid = arrRs1Valid;
        rs1Data  = arrRs1Data;
        rs2Valid = arrRs2Valid;
        rs2Data  = arrRs2Data;
`ifdef SKIP_RB_BYPASS_EN
        if (WbValidIn && (WbRbIdxIn == Rs1IdxIn)) begin
            rs1Valid = 1'b1;
            rs1Data  = WbDataIn;
        end
        if (WbValidIn && (WbRbIdxIn == Rs2IdxIn)) begin
            rs2Valid = 1'b1;
            rs2Data  = WbDataIn;
        end
`endif
        // Disabled or invalid operands read as zero; only enabled ones can miss.
        rspNext.rs1Data = (Rs1ReadEnIn && rs1Valid) ? rs1Data : '0;
        rspNext.rs2Data = (Rs2ReadEnIn && rs2Valid) ? rs2Data : '0;
        rspNext.rdIdx   = RdIdxIn;
        rspNext.miss    = (Rs1ReadEnIn && !rs1Valid) || (Rs2ReadEnIn && !rs2Valid);
    end

    always_ff @(posedge ClockIn) begin
        if (ResetIn) begin
            rspValid <= 1'b0;
            rsp      <= '0;
            hitCount <= '0;
        end else if (reqAccept) begin
            rspValid <= 1'b1;
            rsp      <= rspNext;
            if (!rspNext.miss && (hitCount != HIT_MAX)) begin
                hitCount <= hitCount + 16'd1;
            end
        end else if (RspReadyIn) begin
            rspValid <= 1'b0;
        end
    end

    assign RspValidOut = rspValid;
    assign Rs1DataOut  = rsp.rs1Data;
    assign Rs2DataOut  = rsp.rs2Data;
    assign RdIdxOut    = rsp.rdIdx;
    assign RspMissOut  = rsp.miss;
    assign HitCountOut = hitCount;

endmodule

// File: tb/tb_skip_result_buffer.sv
// Self-checking bench for skip_result_buffer: directed scenarios plus random traffic
// compared against a behavioural buffer model kept here.
module tb_skip_result_buffer;

    logic        ClockIn = 1'b0;
    logic        ResetIn, WbValidIn, InvalidateIn, ReqValidIn, Rs1ReadEnIn, Rs2ReadEnIn, RspReadyIn;
    logic [3:0]  WbRbIdxIn, Rs1IdxIn, Rs2IdxIn, RdIdxIn;
    logic [31:0] WbDataIn;
    logic [15:0] InvalidateMaskIn;
    logic        ReqReadyOut, RspValidOut, RspMissOut;
    logic [31:0] Rs1DataOut, Rs2DataOut;
    logic [3:0]  RdIdxOut;
    logic [15:0] RbValidOut, HitCountOut;

    int nCompared = 0;
    int nMismatched = 0;

    // Behavioural model state
    bit          mValid [16];
    logic [31:0] mData [16];
    bit          expRspValid, expMiss;
    logic [31:0] expRs1, expRs2;
    logic [3:0]  expRd;
    int          expHits;

    always #5 ClockIn = ~ClockIn;

    skip_result_buffer dut (
        .ClockIn(ClockIn), .ResetIn(ResetIn),
        .WbValidIn(WbValidIn), .WbRbIdxIn(WbRbIdxIn), .WbDataIn(WbDataIn),
        .InvalidateIn(InvalidateIn), .InvalidateMaskIn(InvalidateMaskIn),
        .ReqValidIn(ReqValidIn), .ReqReadyOut(ReqReadyOut),
        .Rs1ReadEnIn(Rs1ReadEnIn), .Rs2ReadEnIn(Rs2ReadEnIn),
        .Rs1IdxIn(Rs1IdxIn), .Rs2IdxIn(Rs2IdxIn), .RdIdxIn(RdIdxIn),
        .RspValidOut(RspValidOut), .RspReadyIn(RspReadyIn),
        .Rs1DataOut(Rs1DataOut), .Rs2DataOut(Rs2DataOut), .RdIdxOut(RdIdxOut),
        .RspMissOut(RspMissOut), .RbValidOut(RbValidOut), .HitCountOut(HitCountOut)
    );

    function automatic logic [15:0] modelVec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = mValid[i];
        return v;
    endfunction

    function automatic logic [101:0] modelAll();
        return {expRspValid, expRs1, expRs2, expRd, expMiss, modelVec(), expHits[15:0]};
    endfunction

    function automatic logic [101:0] dutAll();
        return {RspValidOut, Rs1DataOut, Rs2DataOut, RdIdxOut, RspMissOut, RbValidOut, HitCountOut};
    endfunction

    function automatic bit modelReady();
        return !expRspValid || RspReadyIn;
    endfunction

    task automatic idle();
        ResetIn = 0; WbValidIn = 0; WbRbIdxIn = 0; WbDataIn = 0;
        InvalidateIn = 0; InvalidateMaskIn = 0;
        ReqValidIn = 0; Rs1ReadEnIn = 0; Rs2ReadEnIn = 0;
        Rs1IdxIn = 0; Rs2IdxIn = 0; RdIdxIn = 0; RspReadyIn = 1;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit          v1, v2, acc;
        logic [31:0] d1, d2;
        acc = ReqValidIn && modelReady();
        if (ResetIn) begin
            for (int i = 0; i < 16; i++) mValid[i] = 0;
            expRspValid = 0; expMiss = 0; expRs1 = 0; expRs2 = 0; expRd = 0; expHits = 0;
        end else begin
            if (acc) begin
                v1 = mValid[Rs1IdxIn]; d1 = mData[Rs1IdxIn];
                v2 = mValid[Rs2IdxIn]; d2 = mData[Rs2IdxIn];
`ifdef SKIP_RB_BYPASS_EN
                if (WbValidIn && WbRbIdxIn == Rs1IdxIn) begin v1 = 1; d1 = WbDataIn; end
                if (WbValidIn && WbRbIdxIn == Rs2IdxIn) begin v2 = 1; d2 = WbDataIn; end
`endif
                expRspValid = 1;
                expMiss = (Rs1ReadEnIn && !v1) || (Rs2ReadEnIn && !v2);
                expRs1 = (Rs1ReadEnIn && v1) ? d1 : 32'd0;
                expRs2 = (Rs2ReadEnIn && v2) ? d2 : 32'd0;
                expRd = RdIdxIn;
                if (!expMiss && expHits < 65535) expHits = expHits + 1;
            end else if (RspReadyIn) begin
                expRspValid = 0;
            end
            for (int i = 0; i < 16; i++)
                if (InvalidateIn && InvalidateMaskIn[i]) mValid[i] = 0;
            if (WbValidIn) begin
                mValid[WbRbIdxIn] = 1;
                mData[WbRbIdxIn] = WbDataIn;
            end
        end
        @(posedge ClockIn);
        #1;
    endtask

    task automatic test_reset();
        idle();
        ResetIn = 1; WbValidIn = 1; WbRbIdxIn = 4'd6; WbDataIn = 32'h55;
        ReqValidIn = 1; Rs1ReadEnIn = 1; Rs1IdxIn = 4'd6; RdIdxIn = 4'd9;
        tick();
        idle();
        nCompared++;
        if (dutAll() !== 102'd0) begin
            nMismatched++; $display("FAIL reset_outputs: got %h want 0", dutAll());
        end
        #1;
        nCompared++;
        if (ReqReadyOut !== 1'b1) begin
            nMismatched++; $display("FAIL reset_ready: got %b want 1", ReqReadyOut);
        end
    endtask

    task automatic test_write_read();
        idle();
        WbValidIn = 1; WbRbIdxIn = 4'd3; WbDataIn = 32'hDEADBEEF;
        tick();
        idle();
        ReqValidIn = 1; Rs1ReadEnIn = 1; Rs1IdxIn = 4'd3; RdIdxIn = 4'd9;
        tick();
        idle();
        nCompared++;
        if ({RspValidOut, Rs1DataOut, RspMissOut, RbValidOut, RdIdxOut} !== {1'b1, 32'hDEADBEEF, 1'b0, 16'h0008, 4'd9}) begin
            nMismatched++;
            $display("FAIL write_read: got v=%b d=%h miss=%b rbv=%h rd=%0d want v=1 d=deadbeef miss=0 rbv=0008 rd=9",
                     RspValidOut, Rs1DataOut, RspMissOut, RbValidOut, RdIdxOut);
        end
        tick();
        nCompared++;
        if (RspValidOut !== 1'b0) begin
            nMismatched++; $display("FAIL write_read_drain: got valid %b want 0", RspValidOut);
        end
    endtask

    task automatic test_miss();
        int hitsBefore;
        idle();
        hitsBefore = expHits;
        ReqValidIn = 1; Rs1ReadEnIn = 1; Rs1IdxIn = 4'd5; RdIdxIn = 4'd2;
        tick();
        idle();
        nCompared++;
        if ({RspValidOut, Rs1DataOut, RspMissOut, HitCountOut} !== {1'b1, 32'd0, 1'b1, hitsBefore[15:0]}) begin
            nMismatched++;
            $display("FAIL miss_read: got v=%b d=%h miss=%b hits=%0d want v=1 d=0 miss=1 hits=%0d",
                     RspValidOut, Rs1DataOut, RspMissOut, HitCountOut, hitsBefore);
        end
        tick();
    endtask

    task automatic test_stall();
        idle();
        ReqValidIn = 1; Rs1ReadEnIn = 1; Rs1IdxIn = 4'd3; RdIdxIn = 4'd1;
        tick();
        RspReadyIn = 0; Rs1ReadEnIn = 0; Rs2ReadEnIn = 1; Rs2IdxIn = 4'd3; RdIdxIn = 4'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            nCompared++;
            if (ReqReadyOut !== 1'b0) begin
                nMismatched++; $display("FAIL stall_ready: cycle %0d got %b want 0", c, ReqReadyOut);
            end
            tick();
            nCompared++;
            if ({RspValidOut, Rs1DataOut, Rs2DataOut, RdIdxOut} !== {1'b1, 32'hDEADBEEF, 32'd0, 4'd1}) begin
                nMismatched++;
                $display("FAIL stall_hold: cycle %0d got v=%b rs1=%h rs2=%h rd=%0d want v=1 rs1=deadbeef rs2=0 rd=1",
                         c, RspValidOut, Rs1DataOut, Rs2DataOut, RdIdxOut);
            end
        end
        RspReadyIn = 1;
        #1;
        nCompared++;
        if (ReqReadyOut !== 1'b1) begin
            nMismatched++; $display("FAIL stall_release_ready: got %b want 1", ReqReadyOut);
        end
        tick();
        idle();
        nCompared++;
        if ({RspValidOut, Rs1DataOut, Rs2DataOut, RdIdxOut} !== {1'b1, 32'd0, 32'hDEADBEEF, 4'd4}) begin
            nMismatched++;
            $display("FAIL stall_next_req: got v=%b rs1=%h rs2=%h rd=%0d want v=1 rs1=0 rs2=deadbeef rd=4",
                     RspValidOut, Rs1DataOut, Rs2DataOut, RdIdxOut);
        end
        tick();
    endtask

    task automatic test_write_invalidate();
        logic [31:0] wval;
        idle();
        wval = $urandom;
        WbValidIn = 1; WbRbIdxIn = 4'd7; WbDataIn = wval;
        InvalidateIn = 1; InvalidateMaskIn = 16'h0080;
        tick();
        idle();
        nCompared++;
        if (RbValidOut[7] !== 1'b1) begin
            nMismatched++; $display("FAIL wr_inv_valid: got %b want 1", RbValidOut[7]);
        end
        ReqValidIn = 1; Rs1ReadEnIn = 1; Rs1IdxIn = 4'd7;
        tick();
        idle();
        nCompared++;
        if ({Rs1DataOut, RspMissOut} !== {wval, 1'b0}) begin
            nMismatched++;
            $display("FAIL wr_inv_data: got %h miss=%b want %h miss=0", Rs1DataOut, RspMissOut, wval);
        end
        // Invalidate alone must clear the entry.
        InvalidateIn = 1; InvalidateMaskIn = 16'h0080;
        tick();
        idle();
        nCompared++;
        if (RbValidOut !== 16'h0008) begin
            nMismatched++; $display("FAIL inv_only: got %h want 0008", RbValidOut);
        end
    endtask

    task automatic test_bypass();
        logic [32:0] want;
        idle();
        WbValidIn = 1; WbRbIdxIn = 4'd2; WbDataIn = 32'h12;
        ReqValidIn = 1; Rs2ReadEnIn = 1; Rs2IdxIn = 4'd2; RdIdxIn = 4'd11;
        tick();
        idle();
`ifdef SKIP_RB_BYPASS_EN
        want = {32'h12, 1'b0};
`else
        want = {32'h0, 1'b1};
`endif
        nCompared++;
        if ({Rs2DataOut, RspMissOut} !== want) begin
            nMismatched++;
            $display("FAIL bypass: got rs2=%h miss=%b want rs2=%h miss=%b", Rs2DataOut, RspMissOut, want[32:1], want[0]);
        end
        ReqValidIn = 1; Rs2ReadEnIn = 1; Rs2IdxIn = 4'd2;
        tick();
        idle();
        nCompared++;
        if ({Rs2DataOut, RspMissOut} !== {32'h12, 1'b0}) begin
            nMismatched++; $display("FAIL after_write: got rs2=%h miss=%b want rs2=12 miss=0", Rs2DataOut, RspMissOut);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            ResetIn = ($urandom_range(0, 99) == 0);
            WbValidIn = ($urandom_range(0, 2) == 0);
            WbRbIdxIn = 4'($urandom);
            WbDataIn = $urandom;
            InvalidateIn = ($urandom_range(0, 5) == 0);
            InvalidateMaskIn = 16'($urandom);
            ReqValidIn = ($urandom_range(0, 3) != 0);
            Rs1ReadEnIn = $urandom_range(0, 1);
            Rs2ReadEnIn = $urandom_range(0, 1);
            Rs1IdxIn = 4'($urandom);
            Rs2IdxIn = 4'($urandom);
            RdIdxIn = 4'($urandom);
            RspReadyIn = ($urandom_range(0, 3) != 0);
            #1;
            nCompared++;
            if (ReqReadyOut !== modelReady()) begin
                nMismatched++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, ReqReadyOut, modelReady());
            end
            tick();
            nCompared++;
            if (dutAll() !== modelAll()) begin
                nMismatched++; $display("FAIL rand_outputs: cycle %0d got %h want %h", c, dutAll(), modelAll());
            end
        end
        idle();
        tick();
    endtask

    task automatic test_saturate();
        idle();
        ReqValidIn = 1; RspReadyIn = 1;
        for (int c = 0; c < 66000; c++) begin
            tick();
            if (expHits == 65534) begin
                nCompared++;
                if (HitCountOut !== 16'hFFFE) begin
                    nMismatched++; $display("FAIL sat_near: got %h want fffe", HitCountOut);
                end
            end
        end
        idle();
        nCompared++;
        if (HitCountOut !== 16'hFFFF) begin
            nMismatched++; $display("FAIL sat_final: got %h want ffff", HitCountOut);
        end
        nCompared++;
        if (dutAll() !== modelAll()) begin
            nMismatched++; $display("FAIL sat_state: got %h want %h", dutAll(), modelAll());
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        WbValidIn = 1; WbRbIdxIn = 4'd1; WbDataIn = 32'hCAFE0001;
        tick();
        idle();
        ReqValidIn = 1; Rs1ReadEnIn = 1; Rs1IdxIn = 4'd1; RdIdxIn = 4'd8;
        tick();
        RspReadyIn = 0;
        tick();
        ResetIn = 1; WbValidIn = 1; WbRbIdxIn = 4'd9; WbDataIn = 32'h1;
        tick();
        idle();
        nCompared++;
        if (dutAll() !== 102'd0) begin
            nMismatched++; $display("FAIL reset_mid_stall: got %h want 0", dutAll());
        end
        #1;
        nCompared++;
        if (ReqReadyOut !== 1'b1) begin
            nMismatched++; $display("FAIL reset_mid_stall_ready: got %b want 1", ReqReadyOut);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mValid[i] = 0; mData[i] = '0; end
        expRspValid = 0; expMiss = 0; expRs1 = 0; expRs2 = 0; expRd = 0; expHits = 0;
        idle();
        #2;
        test_reset();
        test_write_read();
        test_miss();
        test_stall();
        test_write_invalidate();
        test_bypass();
        test_random();
        test_saturate();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/skip_result_buffer.md
SKIP_RESULT_BUFFER -- requirements
Module: skip_result_buffer

Interface
REQ-001 Parameter RB_DEPTH, 16, number of result-buffer entries; power of two, 4..64.
REQ-002 Parameter DATA_W, 32, width of each stored result.
REQ-003 ClockIn  in  1  single clock; all state changes on posedge.
REQ-004 ResetIn  in  1  synchronous, active-high reset.
REQ-005 WbValidIn  in  1  writeback result write strobe.
REQ-006 WbRbIdxIn  in  log2(RB_DEPTH)  entry written by writeback.
REQ-007 WbDataIn  in  DATA_W  result value to store.
REQ-008 InvalidateIn  in  1  apply InvalidateMaskIn this cycle.
REQ-009 InvalidateMaskIn  in  RB_DEPTH  entries to clear (bit i clears entry i).
REQ-010 ReqValidIn  in  1  read request from fetch skip logic.
REQ-011 ReqReadyOut  out  1  request accepted when ReqValidIn && ReqReadyOut.
REQ-012 Rs1ReadEnIn, Rs2ReadEnIn  in  1 each  per-operand read enables.
REQ-013 Rs1IdxIn, Rs2IdxIn, RdIdxIn  in  log2(RB_DEPTH) each  operand source entries and destination tag.
REQ-014 RspValidOut  out  1  response valid; RspReadyIn  in  1  downstream accepts.
REQ-015 Rs1DataOut, Rs2DataOut  out  DATA_W each  operand values; RdIdxOut  out  log2(RB_DEPTH)  echoed tag.
REQ-016 RspMissOut  out  1  an enabled operand entry was invalid at accept.
REQ-017 RbValidOut  out  RB_DEPTH  per-entry valid bits, fed to fetch RB_ValidIn.
REQ-018 HitCountOut  out  16  saturating count of accepted non-miss requests.

Function
REQ-019 Storage: RB_DEPTH x DATA_W array plus RB_DEPTH valid bits; RbValidOut is the registered valid vector, no combinational path from inputs.
REQ-020 Write: WbValidIn at posedge stores WbDataIn at WbRbIdxIn and sets its valid bit.
REQ-021 Invalidate: InvalidateIn clears valid bits selected by mask; data untouched.
REQ-022 Same-cycle write and invalidate of one entry: write wins, entry ends valid with new data.
REQ-023 ReqReadyOut = !RspValidOut || RspReadyIn (one-deep registered output stage, full throughput).
REQ-024 Accepted request produces RspValidOut=1 on next cycle (latency 1); operand outputs registered.
REQ-025 Disabled operand: its data output is 0 and is excluded from miss evaluation.
REQ-026 Enabled operand with invalid entry: data output 0, RspMissOut=1.
REQ-027 Stall: while RspValidOut && !RspReadyIn all response outputs hold stable.
REQ-028 RspValidOut clears after handshake when no new request accepted the same cycle.
REQ-029 Reads sample array/valid state as of the accept cycle; later writes/invalidates do not alter a held response.
REQ-030 HitCountOut increments by 1 per accepted request with RspMissOut=0 result; saturates at 0xFFFF.

Reset
REQ-031 ResetIn at posedge: all valid bits 0, RspValidOut 0, RspMissOut 0, data outputs 0, RdIdxOut 0, HitCountOut 0; array contents need not be cleared.
REQ-032 ResetIn has priority over every same-cycle write, invalidate and request; an in-flight response is discarded.
REQ-033 ReqReadyOut is 1 in the cycle after reset.

Configuration
REQ-034 Macro SKIP_RB_BYPASS_EN defined: a request accepted in the same cycle as a write to a matching enabled operand index returns WbDataIn, no miss; invalidate-only of that index still misses unless also written.
REQ-035 Macro undefined: reads see pre-write state; same-cycle write to a requested invalid entry yields miss.

Structure
REQ-036 Package VSTypes holds RB_DEPTH default, RbIdxType, and a packed RbRspType (rs1/rs2 data, rd idx, miss).
REQ-037 One sub-module, skip_rb_array (storage, valid bits, write/invalidate priority); handshake, bypass and counter in top.

Verification
REQ-038 Reset, write idx 3 = 0xDEADBEEF, read Rs1Idx=3 -> next cycle RspValidOut=1, Rs1DataOut=0xDEADBEEF, RspMissOut=0, RbValidOut=0x0008.
REQ-039 Read idx 5 never written, Rs1 enabled -> Rs1DataOut=0, RspMissOut=1, HitCountOut unchanged.
REQ-040 RspReadyIn=0 for 3 cycles with response pending -> ReqReadyOut=0, outputs stable; then RspReadyIn=1 -> handshake, next request accepted same cycle.
REQ-041 Write idx 7 and InvalidateMaskIn=0x0080 same cycle -> RbValidOut[7]=1, data = written value.
REQ-042 With SKIP_RB_BYPASS_EN: write idx 2 = 0x12 and request Rs2Idx=2 same cycle -> Rs2DataOut=0x12, no miss; without macro -> miss.
REQ-043 70000 accepted hits -> HitCountOut=0xFFFF; ResetIn mid-stall -> RspValidOut=0, RbValidOut=0 next cycle.
